// File: rtl/alarma_recuperacion_if.sv
// Signal bundle between the alarm supervisor and whoever drives its flags.
// The supervisor uses the slave view; the stimulus/consumer side uses master.
interface alarma_recuperacion_if;
    logic       persistencia;
    logic       fuera_rango;
    logic       ack;
    logic       alarma;
    logic [1:0] estado;
    logic [2:0] contador_rec;
    logic [7:0] num_alarmas;

    modport master (
        output persistencia,
        output fuera_rango,
        output ack,
        input  alarma,
        input  estado,
        input  contador_rec,
        input  num_alarmas
    );

    modport slave (
        input  persistencia,
        input  fuera_rango,
        input  ack,
        output alarma,
        output estado,
        output contador_rec,
        output num_alarmas
    );
endinterface

// File: rtl/alarma_recuperacion.sv
// Alarm supervisor: raises on persistent out-of-range, clears after M in-range cycles.
// Optional macro ALARMA_ACK_EN adds an operator-acknowledge wait before returning to NORMAL.
module alarma_recuperacion #(
    parameter int unsigned M = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    alarma_recuperacion_if.slave  bus
);

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        ALARMA      = 2'd1,
        RECUPERANDO = 2'd2,
        ESPERA_ACK  = 2'd3
    } estado_t;

    localparam logic [3:0] M_LIM = 4'(M);

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_sig;
    logic [7:0] r_num;
    logic [7:0] w_num_sig;
    logic       r_alarma;
    logic [3:0] w_cnt_inc;
    logic       w_fin_rec;

    // ">=" rather than "==" lets M=1 exit on the first in-range cycle after entering recovery
    assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;
    assign w_fin_rec = (w_cnt_inc >= M_LIM);

    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = 3'd0;
        w_num_sig    = r_num;
        case (r_estado)
            NORMAL: begin
                if (bus.persistencia) begin
                    w_estado_sig = ALARMA;
                    if (r_num != 8'hFF) w_num_sig = r_num + 8'd1;
                end
            end
            ALARMA: begin
                if (!bus.fuera_rango) begin
                    w_estado_sig = RECUPERANDO;
                    w_cnt_sig    = 3'd1;
                end
            end
            RECUPERANDO: begin
                if (bus.fuera_rango) begin
                    w_estado_sig = ALARMA;
                end else if (w_fin_rec) begin
`ifdef ALARMA_ACK_EN
                    w_estado_sig = ESPERA_ACK;
`else
                    w_estado_sig = NORMAL;
`endif
                end else begin
                    w_cnt_sig = w_cnt_inc[2:0];
                end
            end
            ESPERA_ACK: begin
                // A fresh excursion outranks an acknowledge arriving in the same cycle
                if (bus.fuera_rango)  w_estado_sig = ALARMA;
                else if (bus.ack)     w_estado_sig = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_estado <= NORMAL;
            r_cnt    <= 3'd0;
            r_num    <= 8'd0;
            r_alarma <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_cnt    <= w_cnt_sig;
            r_num    <= w_num_sig;
            r_alarma <= (w_estado_sig != NORMAL);
        end
    end

    assign bus.alarma       = r_alarma;
    assign bus.estado       = r_estado;
    assign bus.contador_rec = r_cnt;
    assign bus.num_alarmas  = r_num;

endmodule

// File: tb/tb_alarma_recuperacion.sv
// Bench for alarma_recuperacion: M=4 and M=1 instances driven in parallel, checked
// against vector tables, directed sequences and an abstract reference model.
module tb_alarma_recuperacion;

`ifdef ALARMA_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    alarma_recuperacion_if bus4 ();
    alarma_recuperacion_if bus1 ();

    alarma_recuperacion #(.M(4)) dut4 (.clk(clk), .arst_n(arst_n), .bus(bus4.slave));
    alarma_recuperacion #(.M(1)) dut1 (.clk(clk), .arst_n(arst_n), .bus(bus1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit rst_n;
        bit p;
        bit f;
        bit a;
        bit e_al;
        int e_st;
        int e_cnt;
        int e_num;
    } vec_t;

    vec_t tbl[25];

    // Reference model: alarm flag, in-range streak since the last excursion, ack wait, entry count
    int mM[2] = '{4, 1};
    bit m_act[2];
    bit m_wait[2];
    int m_streak[2];
    int m_cnt[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit p, input bit f, input bit a);
        arst_n            = r;
        bus4.persistencia = p;
        bus4.fuera_rango  = f;
        bus4.ack          = a;
        bus1.persistencia = p;
        bus1.fuera_rango  = f;
        bus1.ack          = a;
    endtask

    function automatic int exp_estado(input int k);
        if (!m_act[k])            return 0;
        else if (m_wait[k])       return 3;
        else if (m_streak[k] == 0) return 1;
        else                      return 2;
    endfunction

    task automatic model_step();
        int lim;
        for (int k = 0; k < 2; k++) begin
            lim = (mM[k] < 2) ? 2 : mM[k];
            if (!arst_n) begin
                m_act[k] = 0; m_wait[k] = 0; m_streak[k] = 0; m_cnt[k] = 0;
            end else if (!m_act[k]) begin
                if (bus4.persistencia) begin
                    m_act[k] = 1;
                    m_streak[k] = 0;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
            end else if (m_wait[k]) begin
                if (bus4.fuera_rango) begin
                    m_wait[k] = 0;
                    m_streak[k] = 0;
                end else if (bus4.ack) begin
                    m_wait[k] = 0;
                    m_act[k] = 0;
                end
            end else if (bus4.fuera_rango) begin
                m_streak[k] = 0;
            end else begin
                m_streak[k]++;
                if (m_streak[k] >= lim) begin
                    m_streak[k] = 0;
                    if (ACK_EN) m_wait[k] = 1;
                    else        m_act[k] = 0;
                end
            end
        end
    endtask

    task automatic cmp_model(input int k, input logic al, input logic [1:0] st,
                             input logic [2:0] cn, input logic [7:0] nm);
        int es;
        es = exp_estado(k);
        check($sformatf("model_alarma_M%0d", mM[k]), int'(al), int'(m_act[k]));
        check($sformatf("model_estado_M%0d", mM[k]), int'(st), es);
        check($sformatf("model_contador_M%0d", mM[k]), int'(cn), (es == 2) ? m_streak[k] : 0);
        check($sformatf("model_num_M%0d", mM[k]), int'(nm), m_cnt[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_model(0, bus4.alarma, bus4.estado, bus4.contador_rec, bus4.num_alarmas);
        cmp_model(1, bus1.alarma, bus1.estado, bus1.contador_rec, bus1.num_alarmas);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // reset with alarm pending, entry, count-up, exit/ack, relapse, ack ignored, collision, resets
        tbl[0]  = '{0, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 1, 1, 0, 1};
        tbl[3]  = '{1, 0, 0, 0, 1, 2, 1, 1};
        tbl[4]  = '{1, 0, 0, 0, 1, 2, 2, 1};
        tbl[5]  = '{1, 0, 0, 0, 1, 2, 3, 1};
        tbl[6]  = '{1, 0, 0, 1, ACK_EN, ACK_EN ? 3 : 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{1, 1, 1, 0, 1, 1, 0, 2};
        tbl[9]  = '{1, 0, 0, 0, 1, 2, 1, 2};
        tbl[10] = '{1, 0, 0, 0, 1, 2, 2, 2};
        tbl[11] = '{1, 0, 1, 0, 1, 1, 0, 2};
        tbl[12] = '{1, 0, 1, 0, 1, 1, 0, 2};
        tbl[13] = '{1, 0, 0, 1, 1, 2, 1, 2};
        tbl[14] = '{1, 0, 0, 1, 1, 2, 2, 2};
        tbl[15] = '{1, 0, 0, 1, 1, 2, 3, 2};
        tbl[16] = '{1, 0, 0, 0, ACK_EN, ACK_EN ? 3 : 0, 0, 2};
        tbl[17] = '{1, 0, 1, 1, ACK_EN, ACK_EN ? 1 : 0, 0, 2};
        tbl[18] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[19] = '{1, 0, 1, 0, 0, 0, 0, 0};
        tbl[20] = '{1, 1, 1, 0, 1, 1, 0, 1};
        tbl[21] = '{1, 0, 0, 0, 1, 2, 1, 1};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[23] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[24] = '{1, 1, 0, 0, 1, 1, 0, 1};

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst_n, tbl[i].p, tbl[i].f, tbl[i].a);
            tick();
            check($sformatf("tbl%0d_alarma", i), int'(bus4.alarma), int'(tbl[i].e_al));
            check($sformatf("tbl%0d_estado", i), int'(bus4.estado), tbl[i].e_st);
            check($sformatf("tbl%0d_contador", i), int'(bus4.contador_rec), tbl[i].e_cnt);
            check($sformatf("tbl%0d_num", i), int'(bus4.num_alarmas), tbl[i].e_num);
        end

        // M=1: one in-range cycle in recovery is enough
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
        check("m1_estado_alarma", int'(bus1.estado), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        check("m1_estado_rec", int'(bus1.estado), 2);
        check("m1_contador_rec", int'(bus1.contador_rec), 1);
        tick();
        check("m1_estado_exit", int'(bus1.estado), ACK_EN ? 3 : 0);
        check("m1_alarma_exit", int'(bus1.alarma), ACK_EN ? 1 : 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
        check("m1_estado_final", int'(bus1.estado), 0);

        // Saturation of the entry counter
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int n = 0; n < 260; n++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) tick();
            drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
        end
        check("sat_num_M4", int'(bus4.num_alarmas), 255);
        check("sat_num_M1", int'(bus1.num_alarmas), 255);
        check("sat_estado_M4", int'(bus4.estado), 0);

        // Random traffic against the model
        drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarma_recuperacion.md
ALARMA_RECUPERACION -- requirements
Module: alarma_recuperacion

Interface
REQ-001 The block SHALL have parameter M, default 4, meaning the number of consecutive in-range cycles required to end recovery (legal 1..7).
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock (rising edge).
REQ-003 The block SHALL have port arst_n, input, 1, meaning the synchronous active-low reset, sampled on rising clk.
REQ-004 The block SHALL have port persistencia, input, 1, meaning the persistence-qualified out-of-range flag, one sample per cycle.
REQ-005 The block SHALL have port fuera_rango, input, 1, meaning the raw out-of-range flag for the current cycle.
REQ-006 The block SHALL have port ack, input, 1, meaning the operator acknowledge, level-sampled each cycle.
REQ-007 The block SHALL have port alarma, output, 1, meaning the registered alarm indication.
REQ-008 The block SHALL have port estado, output, 2, meaning the current FSM state encoding.
REQ-009 The block SHALL have port contador_rec, output, 3, meaning the consecutive in-range cycle count during recovery.
REQ-010 The block SHALL have port num_alarmas, output, 8, meaning the number of NORMAL->ALARMA entries, saturating.

Function
REQ-011 The FSM SHALL have states NORMAL=2'd0, ALARMA=2'd1, RECUPERANDO=2'd2 and ESPERA_ACK=2'd3, and estado SHALL equal the state register.
REQ-012 alarma SHALL be 0 in NORMAL and 1 in every other state, registered with the state, so it asserts one cycle after persistencia is sampled high.
REQ-013 In NORMAL, persistencia=1 SHALL transition to ALARMA and increment num_alarmas; otherwise the FSM SHALL stay in NORMAL.
REQ-014 In ALARMA, fuera_rango=0 SHALL transition to RECUPERANDO with contador_rec loaded to 1; fuera_rango=1 SHALL hold ALARMA with contador_rec=0.
REQ-015 In RECUPERANDO, fuera_rango=1 SHALL return to ALARMA and clear contador_rec; no num_alarmas increment.
REQ-016 In RECUPERANDO, fuera_rango=0 SHALL increment contador_rec, and when the incremented value equals M the FSM SHALL leave RECUPERANDO (REQ-025/026), with contador_rec cleared on exit.
REQ-017 For M=1, the ALARMA->RECUPERANDO cycle SHALL already satisfy the exit condition, so the FSM SHALL exit on the next in-range cycle with no extra count.
REQ-018 In ESPERA_ACK, fuera_rango=1 SHALL return to ALARMA and take priority over a simultaneous ack.
REQ-019 In ESPERA_ACK, ack=1 with fuera_rango=0 SHALL transition to NORMAL.
REQ-020 ack SHALL be ignored in NORMAL, ALARMA and RECUPERANDO; ack held high before ESPERA_ACK SHALL act in the first ESPERA_ACK cycle.
REQ-021 num_alarmas SHALL saturate at 8'd255 and never wrap.
REQ-022 contador_rec SHALL be 0 in every state except RECUPERANDO, and SHALL never exceed M.

Reset
REQ-023 When arst_n=0 at a rising clk edge, the block SHALL set state=NORMAL, alarma=0, estado=2'd0, contador_rec=3'd0 and num_alarmas=8'd0, regardless of the current state or inputs.
REQ-024 Reset asserted mid-alarm or mid-recovery SHALL discard the recovery progress, and the first cycle after release SHALL evaluate as NORMAL.

Configuration
REQ-025 With macro ALARMA_ACK_EN defined, RECUPERANDO reaching M SHALL transition to ESPERA_ACK with alarma held at 1 until ack (REQ-019).
REQ-026 With ALARMA_ACK_EN undefined, RECUPERANDO reaching M SHALL transition directly to NORMAL with alarma=0 the next cycle; ESPERA_ACK SHALL be unreachable and ack ignored.

Verification
REQ-027 The bench SHALL check reset: drive arst_n=0 for 2 cycles with persistencia=1 -> all outputs 0, estado=0.
REQ-028 The bench SHALL check the basic alarm cycle with M=4 and ALARMA_ACK_EN defined:
- Stimulus: persistencia=1 for 1 cycle, then fuera_rango=0 for 4 cycles.
- Response: alarma=1 from cycle+1, contador_rec 1,2,3, then estado=3; ack=1 gives estado=0, alarma=0, num_alarmas=1.
REQ-029 The bench SHALL check a relapse with M=4: fuera_rango=0,0,1 in RECUPERANDO -> contador_rec 1,2 then 0, estado=1, and num_alarmas unchanged.
REQ-030 The bench SHALL check the collision in ESPERA_ACK: ack=1 and fuera_rango=1 in the same cycle -> estado=1, alarma stays 1.
REQ-031 The bench SHALL check saturation: 260 alarm/clear cycles -> num_alarmas=255.
REQ-032 The bench SHALL check the build without ALARMA_ACK_EN, M=1: persistencia pulse, then fuera_rango=0 for 2 cycles -> estado 1,2,0, with ack never required.
